// File: rtl/adder_multicycle_nbit_if.sv
// Operand/result bundle for the multi-cycle slice adder.
// Names are seen from the adder: i_* flow into it, o_* flow out of it.
// Start/busy/done handshake; no flow control beyond busy.
interface adder_multicycle_nbit_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 i_start;
  logic [BIT_WIDTH-1:0] i_a;
  logic [BIT_WIDTH-1:0] i_b;
  logic                 i_carry_in;
  logic                 i_sub;
  logic                 o_busy;
  logic                 o_done;
  logic [BIT_WIDTH-1:0] o_sum;
  logic                 o_overflow;

  // Requester side: drives the operation request, observes status/result.
  modport master (
    output i_start, i_a, i_b, i_carry_in, i_sub,
    input  o_busy, o_done, o_sum, o_overflow
  );

  // Adder side.
  modport slave (
    input  i_start, i_a, i_b, i_carry_in, i_sub,
    output o_busy, o_done, o_sum, o_overflow
  );
endinterface

// File: rtl/adder_multicycle_nbit.sv
// Multi-cycle ripple adder/subtractor: one SLICE_WIDTH slice per clock, LSB slice first.
// Latency: done rises NUM_SLICES edges after the accepting edge; a new start in DONE chains directly.
// Backpressure: start is ignored while busy; result registers hold until the next completion.
module adder_multicycle_nbit #(
  parameter int BIT_WIDTH   = 16,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  adder_multicycle_nbit_if.slave bus
);

  localparam int NUM_SLICES = BIT_WIDTH / SLICE_WIDTH;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0]     LAST_IDX   = CNT_W'(NUM_SLICES - 1);
  localparam logic [BIT_WIDTH-1:0] SLICE_MASK = BIT_WIDTH'({SLICE_WIDTH{1'b1}});

  // Reject parameter sets that cannot be cut into whole slices.
  generate
    if ((SLICE_WIDTH < 1) || (NUM_SLICES < 1) || ((BIT_WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_params
      $error("adder_multicycle_nbit: BIT_WIDTH must be a positive multiple of SLICE_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIT_WIDTH-1:0] r_a;
  logic [BIT_WIDTH-1:0] r_b;        // already inverted when subtracting
  logic                 r_carry;    // carry into the slice being processed
  logic [CNT_W-1:0]     r_cnt;      // index of the slice being processed
  logic [BIT_WIDTH-1:0] r_work;     // partial result, filled slice by slice
  logic [BIT_WIDTH-1:0] r_sum;
  logic                 r_overflow;

  logic                   w_accept;
  logic                   w_last;
  logic [31:0]            w_base;
  logic [SLICE_WIDTH-1:0] w_a_slice;
  logic [SLICE_WIDTH-1:0] w_b_slice;
  logic [SLICE_WIDTH:0]   w_slice_res;
  logic [BIT_WIDTH-1:0]   w_work_merged;

  // Slice datapath: select slice r_cnt, add with the carry from the previous cycle,
  // and form the working word with this slice merged in.
  always_comb begin
    w_base        = 32'(r_cnt) * 32'(SLICE_WIDTH);
    w_a_slice     = SLICE_WIDTH'(r_a >> w_base);
    w_b_slice     = SLICE_WIDTH'(r_b >> w_base);
    w_slice_res   = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE_WIDTH{1'b0}}, r_carry};
    w_work_merged = (r_work & ~(SLICE_MASK << w_base))
                  | (BIT_WIDTH'(w_slice_res[SLICE_WIDTH-1:0]) << w_base);
  end

  // Next state and status outputs; start only counts outside CALC.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_cnt == LAST_IDX);
    bus.o_busy  = 1'b0;
    bus.o_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        bus.o_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.o_done = 1'b1;
        if (bus.i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, operand capture, per-slice accumulation and result publish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_work     <= '0;
      r_sum      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= bus.i_a;
        r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
        r_carry <= bus.i_carry_in;
        r_cnt   <= '0;
        r_work  <= '0;
      end else if (r_state == ST_CALC) begin
        r_work  <= w_work_merged;
        r_carry <= w_slice_res[SLICE_WIDTH];
        r_cnt   <= r_cnt + 1'b1;
        // Only the final slice updates the visible result, so partial sums never leak out.
        if (w_last) begin
          r_sum      <= w_work_merged;
          r_overflow <= w_slice_res[SLICE_WIDTH];
        end
      end
    end
  end

  assign bus.o_sum      = r_sum;
  assign bus.o_overflow = r_overflow;

endmodule
